// File: rtl/prf_sequencer.sv
// PRF sequencer: per-period carrier select, burst, ADC and range-gate windows for the CLK64 generator.
// Outputs registered (1 cycle after state); RUN seen at edge k gives PRF_SYNC at edge k+1; no backpressure.
module prf_sequencer #(
  parameter int PW      = 16,
  parameter int GW      = 12,
  parameter int MIN_PER = 16
) (
  input  logic          CLK64,
  input  logic          RES,
  input  logic          RUN,
  input  logic [1:0]    FREQ_SEL,
  input  logic [3:0]    BURST_CYC,
  input  logic [GW-1:0] GATE_DLY,
  input  logic [GW-1:0] GATE_LEN,
  input  logic [PW-1:0] PRF_PER,
  output logic          F8,
  output logic          F4,
  output logic          F2,
  output logic          WR_Freq,
  output logic          BURST_EN,
  output logic          ADC_EN,
  output logic          SMPL_EN,
  output logic          PRF_SYNC,
  output logic          CFG_ERR,
  output logic          OVR
);

  localparam int AW = PW + 1;
  localparam logic [AW-1:0] PE_MAX = AW'({PW{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_BURST,
    S_DLY,
    S_GATE,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_nxt_state;
  logic [PW-1:0] r_pos;
  logic [PW-1:0] w_nxt_pos;

  // Period configuration, captured when pos 0 is issued
  logic [AW-1:0] r_eb;
  logic [AW-1:0] r_gs;
  logic [AW-1:0] r_ge;
  logic [AW-1:0] r_pe;
  logic          r_ovr;
  logic          r_len_nz;

  // Registered outputs; F-lines kept as {F8,F4,F2}
  logic [2:0]    r_f;
  logic          r_wr;
  logic          r_burst;
  logic          r_adc;
  logic          r_smpl;
  logic          r_sync;
  logic          r_cfg_err;
  logic          r_ovr_p;

  logic [2:0]    w_f_new;
  logic [AW-1:0] w_tc;
  logic [AW-1:0] w_eb;
  logic [AW-1:0] w_gs_raw;
  logic          w_gs_clamp;
  logic [AW-1:0] w_gs;
  logic [AW-1:0] w_ge;
  logic [AW-1:0] w_per;
  logic [AW-1:0] w_need;
  logic          w_sat;
  logic [AW-1:0] w_pe;
  logic          w_ovr;
  logic          w_cfg_err;

  logic          w_last;
  logic [AW-1:0] w_inc;
  logic          w_sync;
  logic [2:0]    w_f;
  logic          w_wr;
  logic          w_burst;
  logic          w_adc;
  logic          w_smpl;
  logic          w_cfg;
  logic          w_ovr_p;

  // Derived timing from the live inputs; only consumed on the pos-0 edge
  always_comb begin
    w_f_new = r_f;
    case (FREQ_SEL)
      2'd0:    w_f_new = 3'b001;
      2'd1:    w_f_new = 3'b010;
      2'd2:    w_f_new = 3'b100;
      default: w_f_new = r_f;
    endcase

    if (w_f_new[2])      w_tc = AW'(8);
    else if (w_f_new[1]) w_tc = AW'(16);
    else                 w_tc = AW'(32);

    w_eb       = AW'(4) + AW'(BURST_CYC) * w_tc;
    w_gs_raw   = AW'(4) + AW'(GATE_DLY);
    w_gs_clamp = (w_gs_raw < w_eb);
    w_gs       = w_gs_clamp ? w_eb : w_gs_raw;
    w_ge       = w_gs + AW'(GATE_LEN);
    w_per      = (AW'(PRF_PER) < AW'(MIN_PER)) ? AW'(MIN_PER) : AW'(PRF_PER);
    w_need     = w_ge + AW'(1);
    w_sat      = (w_need > PE_MAX);

    if (w_sat)               w_pe = PE_MAX;
    else if (w_need > w_per) w_pe = w_need;
    else                     w_pe = w_per;

    w_ovr     = w_sat || (w_pe > w_per);
    w_cfg_err = (FREQ_SEL == 2'd3) || w_gs_clamp;
  end

  always_ff @(posedge CLK64) begin
    if (RES) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_pos   <= w_nxt_pos;
    end
  end

  // Next state follows the phase of the next pos, so zero-length phases never occupy a cycle
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pos   = r_pos;
    w_inc       = AW'(r_pos) + AW'(1);
    w_last      = (r_state != S_IDLE) && (r_pos != '0) && (AW'(r_pos) == r_pe - AW'(1));

    case (r_state)
      S_IDLE: begin
        if (RUN) begin
          w_nxt_state = S_PRE;
          w_nxt_pos   = '0;
        end
      end
      default: begin
        if (w_last) begin
          w_nxt_state = RUN ? S_PRE : S_IDLE;
          w_nxt_pos   = '0;
        end else begin
          w_nxt_pos = w_inc[PW-1:0];
          if (w_inc < AW'(4))     w_nxt_state = S_PRE;
          else if (w_inc < r_eb)  w_nxt_state = S_BURST;
          else if (w_inc < r_gs)  w_nxt_state = S_DLY;
          else if (w_inc < r_ge)  w_nxt_state = S_GATE;
          else                    w_nxt_state = S_WAIT;
        end
      end
    endcase
  end

  always_comb begin
    w_sync  = (r_state == S_PRE) && (r_pos == '0);
    w_f     = w_sync ? w_f_new : r_f;
    w_cfg   = w_sync && w_cfg_err;
    w_wr    = (r_state == S_PRE) && ((r_pos == PW'(1)) || (r_pos == PW'(2)));
    w_burst = (r_state == S_BURST);
    w_smpl  = (r_state == S_GATE);
    // ADC clock runs from burst end through the gate so the generator stays in sync
    w_adc   = ((r_state == S_DLY) && r_len_nz) || (r_state == S_GATE);
    w_ovr_p = w_last && r_ovr;
  end

  always_ff @(posedge CLK64) begin
    if (RES) begin
      r_f       <= '0;
      r_wr      <= 1'b0;
      r_burst   <= 1'b0;
      r_adc     <= 1'b0;
      r_smpl    <= 1'b0;
      r_sync    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_ovr_p   <= 1'b0;
      r_eb      <= '0;
      r_gs      <= '0;
      r_ge      <= '0;
      r_pe      <= '0;
      r_ovr     <= 1'b0;
      r_len_nz  <= 1'b0;
    end else begin
      r_f       <= w_f;
      r_wr      <= w_wr;
      r_burst   <= w_burst;
      r_adc     <= w_adc;
      r_smpl    <= w_smpl;
      r_sync    <= w_sync;
      r_cfg_err <= w_cfg;
      r_ovr_p   <= w_ovr_p;
      if (w_sync) begin
        r_eb     <= w_eb;
        r_gs     <= w_gs;
        r_ge     <= w_ge;
        r_pe     <= w_pe;
        r_ovr    <= w_ovr;
        r_len_nz <= (GATE_LEN != '0);
      end
    end
  end

  assign F8       = r_f[2];
  assign F4       = r_f[1];
  assign F2       = r_f[0];
  assign WR_Freq  = r_wr;
  assign BURST_EN = r_burst;
  assign ADC_EN   = r_adc;
  assign SMPL_EN  = r_smpl;
  assign PRF_SYNC = r_sync;
  assign CFG_ERR  = r_cfg_err;
  assign OVR      = r_ovr_p;

endmodule

// File: tb/tb_prf_sequencer.sv
// Directed bench for prf_sequencer: measures whole periods and compares window edges to hand-derived values.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_prf_sequencer;

  logic        CLK64;
  logic        RES;
  logic        RUN;
  logic [1:0]  FREQ_SEL;
  logic [3:0]  BURST_CYC;
  logic [11:0] GATE_DLY;
  logic [11:0] GATE_LEN;
  logic [15:0] PRF_PER;
  logic        F8, F4, F2, WR_Freq, BURST_EN, ADC_EN, SMPL_EN, PRF_SYNC, CFG_ERR, OVR;

  prf_sequencer #(.PW(16), .GW(12), .MIN_PER(16)) dut (
    .CLK64(CLK64), .RES(RES), .RUN(RUN), .FREQ_SEL(FREQ_SEL), .BURST_CYC(BURST_CYC),
    .GATE_DLY(GATE_DLY), .GATE_LEN(GATE_LEN), .PRF_PER(PRF_PER),
    .F8(F8), .F4(F4), .F2(F2), .WR_Freq(WR_Freq), .BURST_EN(BURST_EN), .ADC_EN(ADC_EN),
    .SMPL_EN(SMPL_EN), .PRF_SYNC(PRF_SYNC), .CFG_ERR(CFG_ERR), .OVR(OVR)
  );

  initial CLK64 = 1'b0;
  always #5 CLK64 = ~CLK64;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-period measurements: index 0 wr, 1 burst, 2 adc, 3 smpl, 4 ovr
  int m_first[5];
  int m_last[5];
  int m_cnt[5];
  int m_len;
  int m_f0;
  int m_cfg0;
  int m_fchg;
  int m_clash;

  // Staged configuration applied by act code 1
  logic [1:0]  st_freq;
  logic [3:0]  st_burst;
  logic [11:0] st_dly;
  logic [11:0] st_len;
  logic [15:0] st_per;

  wire [9:0] all_out = {F8, F4, F2, WR_Freq, BURST_EN, ADC_EN, SMPL_EN, PRF_SYNC, CFG_ERR, OVR};

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic stage(input int f, input int b, input int d, input int l, input int p);
    st_freq  = 2'(f);
    st_burst = 4'(b);
    st_dly   = 12'(d);
    st_len   = 12'(l);
    st_per   = 16'(p);
  endtask

  task automatic apply(input int code);
    case (code)
      1: begin
        FREQ_SEL  = st_freq;
        BURST_CYC = st_burst;
        GATE_DLY  = st_dly;
        GATE_LEN  = st_len;
        PRF_PER   = st_per;
      end
      2: FREQ_SEL = 2'd1;
      3: FREQ_SEL = 2'd3;
      4: RUN = 1'b0;
      default: ;
    endcase
  endtask

  task automatic wait_sync(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!PRF_SYNC && n < 50) begin
      @(negedge CLK64);
      n++;
    end
    chk({tag, ".sync_latency"}, n, exp_lat);
  endtask

  // Entered on the falling edge where PRF_SYNC is high; returns at the next one (or after 1200 cycles)
  task automatic measure(input int act_pos, input int act_code);
    int pos;
    bit done;
    logic [4:0] s;
    for (int i = 0; i < 5; i++) begin
      m_first[i] = -1;
      m_last[i]  = -1;
      m_cnt[i]   = 0;
    end
    m_f0 = int'({F8, F4, F2});
    m_cfg0 = int'(CFG_ERR);
    m_fchg = 0;
    m_clash = 0;
    m_len = -1;
    pos = 0;
    done = 1'b0;
    while (!done) begin
      s = {OVR, SMPL_EN, ADC_EN, BURST_EN, WR_Freq};
      for (int i = 0; i < 5; i++) begin
        if (s[i]) begin
          if (m_first[i] < 0) m_first[i] = pos;
          m_last[i] = pos;
          m_cnt[i]++;
        end
      end
      if (int'({F8, F4, F2}) != m_f0) m_fchg++;
      if ((BURST_EN && SMPL_EN) || (BURST_EN && WR_Freq)) m_clash++;
      if (pos == act_pos) apply(act_code);
      @(negedge CLK64);
      pos++;
      if (PRF_SYNC) begin
        m_len = pos;
        done = 1'b1;
      end else if (pos >= 1200) begin
        done = 1'b1;
      end
    end
  endtask

  task automatic chk_period(input string t, input int len, input int f, input int cfg,
                            input int wf, input int wl, input int bf, input int bl,
                            input int af, input int al, input int sf, input int sl, input int o);
    string nm[5];
    int ef[5];
    int el[5];
    nm = '{"wr", "burst", "adc", "smpl", "ovr"};
    ef = '{wf, bf, af, sf, o};
    el = '{wl, bl, al, sl, o};
    chk({t, ".len"}, m_len, len);
    chk({t, ".flines"}, m_f0, f);
    chk({t, ".fline_changes"}, m_fchg, 0);
    chk({t, ".cfg_err"}, m_cfg0, cfg);
    chk({t, ".overlap"}, m_clash, 0);
    for (int i = 0; i < 5; i++) begin
      chk({t, ".", nm[i], "_first"}, m_first[i], ef[i]);
      chk({t, ".", nm[i], "_last"}, m_last[i], el[i]);
      chk({t, ".", nm[i], "_count"}, m_cnt[i], (el[i] < 0) ? 0 : el[i] - ef[i] + 1);
    end
  endtask

  initial begin
    RES = 1'b1;
    RUN = 1'b0;
    FREQ_SEL = 2'd0;
    BURST_CYC = 4'd0;
    GATE_DLY = 12'd0;
    GATE_LEN = 12'd0;
    PRF_PER = 16'd0;
    stage(0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK64);
    chk("reset.outputs", int'(all_out), 0);
    RES = 1'b0;
    repeat (3) @(negedge CLK64);
    chk("idle.outputs", int'(all_out), 0);

    // P1: 8 MHz baseline; next config staged mid-period must not disturb it
    FREQ_SEL = 2'd2; BURST_CYC = 4'd4; GATE_DLY = 12'd100; GATE_LEN = 12'd32; PRF_PER = 16'd1000;
    RUN = 1'b1;
    wait_sync("p1", 2);
    stage(0, 3, 50, 32, 1000);
    measure(500, 1);
    chk_period("p1", 1000, 3'b100, 0, 1, 2, 4, 35, 36, 135, 104, 135, -1);

    // P2: 2 MHz, gate start clamped to burst end
    stage(2, 4, 180, 64, 200);
    measure(999, 1);
    chk_period("p2", 1000, 3'b001, 1, 1, 2, 4, 99, 100, 131, 100, 131, -1);

    // P3: gate overruns PRF_PER, period stretched to 249
    stage(2, 4, 100, 32, 1000);
    measure(248, 1);
    chk_period("p3", 249, 3'b100, 0, 1, 2, 4, 35, 36, 247, 184, 247, 248);

    // P4: FREQ_SEL changed to 4 MHz at pos 500, F-lines hold
    measure(500, 2);
    chk_period("p4", 1000, 3'b100, 0, 1, 2, 4, 35, 36, 135, 104, 135, -1);

    // P5: 4 MHz now active; reserved FREQ_SEL staged for next period
    measure(999, 3);
    chk_period("p5", 1000, 3'b010, 0, 1, 2, 4, 67, 68, 135, 104, 135, -1);

    // P6: reserved carrier keeps 4 MHz, CFG_ERR; RUN dropped inside the burst
    measure(20, 4);
    chk_period("p6", -1, 3'b010, 1, 1, 2, 4, 67, 68, 135, 104, 135, -1);
    chk("p6.idle_outputs", int'(all_out), 10'b0100000000);

    // P7: receive-only, no gate, PRF_PER below minimum
    FREQ_SEL = 2'd2; BURST_CYC = 4'd0; GATE_DLY = 12'd0; GATE_LEN = 12'd0; PRF_PER = 16'd5;
    RUN = 1'b1;
    wait_sync("p7", 2);
    stage(2, 4, 100, 32, 1000);
    measure(15, 1);
    chk_period("p7", 16, 3'b100, 0, 1, 2, -1, -1, -1, -1, -1, -1, -1);

    // P8: reset in the middle of the burst
    repeat (20) @(negedge CLK64);
    chk("p8.burst_at_pos20", int'(BURST_EN), 1);
    RES = 1'b1;
    RUN = 1'b0;
    @(negedge CLK64);
    chk("p8.reset_outputs", int'(all_out), 0);
    RES = 1'b0;
    repeat (5) @(negedge CLK64);
    chk("p8.idle_after_reset", int'(all_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
